weight_update_sequencer: RTL

// - Owns one neuron's weight register file (N_WEIGHTS reals) and sequences the shared weight-update

---
 rtl/weight_update_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/weight_update_sequencer.sv
// Weight register file plus a sequencer that walks every weight through an external update datapath.
// Optional build macro: WUS_WEIGHT_CLAMP_EN clamps write-back values to +/-WEIGHT_LIMIT.
module weight_update_sequencer #(
  parameter int  N_WEIGHTS    = 4,
  parameter int  IDX_W        = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1,
  parameter real INIT_WEIGHT  = 0.0,
  parameter real WEIGHT_LIMIT = 4.0
) (
  input  logic             wus_clk,
  input  logic             wus_rst,
  input  logic             wus_start,
  input  real              wus_back_prop,
  input  real              wus_axon,
  input  real              wus_training_ratio,
  input  logic             wus_wr_en,
  input  logic [IDX_W-1:0] wus_wr_idx,
  input  real              wus_wr_data,
  input  logic [IDX_W-1:0] wus_rd_idx,
  output real              wus_rd_data,
  output real              wus_dp_weight,
  output real              wus_dp_back_prop,
  output real              wus_dp_axon,
  output real              wus_dp_training_ratio,
  input  real              wus_dp_weight_new,
  output logic             wus_busy,
  output logic             wus_done,
  output logic [15:0]      wus_pass_count,
  output logic             wus_clamp_hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  real              weights [N_WEIGHTS];
  real              bp_q, axon_q, rate_q;
  real              wb_value;
  logic             last_idx, wr_ok, rd_ok, accept;

  assign last_idx = (int'(idx) == N_WEIGHTS - 1);
  assign wr_ok    = (int'(wus_wr_idx) < N_WEIGHTS);
  assign rd_ok    = (int'(wus_rd_idx) < N_WEIGHTS);
  assign accept   = (state == S_IDLE) && wus_start;

  always_ff @(posedge wus_clk or posedge wus_rst) begin
    if (wus_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    wus_busy   = 1'b0;
    wus_done   = 1'b0;
    case (state)
      S_IDLE: if (wus_start) state_next = S_RUN;
      S_RUN: begin
        wus_busy = 1'b1;
        if (last_idx) state_next = S_DONE;
      end
      S_DONE: begin
        wus_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wus_dp_weight         = weights[idx];
    wus_dp_back_prop      = bp_q;
    wus_dp_axon           = axon_q;
    wus_dp_training_ratio = rate_q;
    wus_rd_data           = rd_ok ? weights[wus_rd_idx] : 0.0;
  end

`ifdef WUS_WEIGHT_CLAMP_EN
  logic clamp_now, clamp_hit_q;

  always_comb begin
    clamp_now = 1'b0;
    wb_value  = wus_dp_weight_new;
    if (wus_dp_weight_new > WEIGHT_LIMIT) begin
      wb_value  = WEIGHT_LIMIT;
      clamp_now = 1'b1;
    end else if (wus_dp_weight_new < -WEIGHT_LIMIT) begin
      wb_value  = -WEIGHT_LIMIT;
      clamp_now = 1'b1;
    end
  end

  // Sticky until the next accepted start clears it.
  always_ff @(posedge wus_clk or posedge wus_rst) begin
    if (wus_rst)                          clamp_hit_q <= 1'b0;
    else if (accept)                      clamp_hit_q <= 1'b0;
    else if (state == S_RUN && clamp_now) clamp_hit_q <= 1'b1;
  end

  assign wus_clamp_hit = clamp_hit_q;
`else
  always_comb wb_value = wus_dp_weight_new;
  assign wus_clamp_hit = 1'b0;
`endif

  always_ff @(posedge wus_clk or posedge wus_rst) begin
    if (wus_rst) begin
      idx            <= '0;
      bp_q           <= 0.0;
      axon_q         <= 0.0;
      rate_q         <= 0.0;
      wus_pass_count <= '0;
      for (int unsigned i = 0; i < N_WEIGHTS; i++) weights[i] <= INIT_WEIGHT;
    end else begin
      case (state)
        S_IDLE: begin
          // A host write coinciding with start lands before RUN reads it.
          if (wus_wr_en && wr_ok) weights[wus_wr_idx] <= wus_wr_data;
          if (wus_start) begin
            bp_q   <= wus_back_prop;
            axon_q <= wus_axon;
            rate_q <= wus_training_ratio;
            idx    <= '0;
          end
        end
        S_RUN: begin
          weights[idx] <= wb_value;
          idx          <= last_idx ? '0 : idx + IDX_W'(1);
        end
        S_DONE: wus_pass_count <= wus_pass_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
